regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised general-purpose register file for the CPU datapath: 2 combinational read ports, 1 synchronous write port, and a per-register busy scoreboard. The decode stage uses the scoreboard to detect hazards on registers whose long-latency result (load, multi-cycle ALU op) has not yet been written back. It replaces the fixed 8 x 16-bit register file. Word width, register count and hardwired-zero behaviour are configurable.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W
- ZERO_R0, 0, 1 = register 0 hardwired to zero (writes and busy-marks to r0 ignored)

Ports (reset is asynchronous, active-high; clock is clk):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers, busy bits, counter
- we  in  1  write enable for write-back port
- addr_w  in  ADDR_W  write-back register address
- data_w  in  DATA_W  write-back data
- set_busy  in  1  mark addr_busy as pending (issue of long-latency op)
- addr_busy  in  ADDR_W  register to mark busy
- addr_a  in  ADDR_W  read port A address
- addr_b  in  ADDR_W  read port B address
- data_a  out  DATA_W  read port A data
- data_b  out  DATA_W  read port B data
- busy_a  out  1  register at addr_a has a pending write
- busy_b  out  1  register at addr_b has a pending write
- pending_cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: NREGS x DATA_W registers `regs[]` and NREGS busy bits `busy[]`.
- Write: on clk rising edge with we=1, regs[addr_w] <= data_w and busy[addr_w] <= 0.
- Busy mark: on clk rising edge with set_busy=1, busy[addr_busy] <= 1.
- Simultaneous we and set_busy to the same address: data is written and busy ends at 1 (the new issue wins over retirement).
- Simultaneous we and set_busy to different addresses: both take effect.
- Write to a non-busy register is legal; busy stays 0.
- Read ports are combinational: data_a = regs[addr_a], busy_a = busy[addr_a]. Port B behaves identically.
- Both ports may read the same address; port B is independent of port A.
- ZERO_R0=1:
  - we or set_busy targeting address 0 has no effect.
  - Reads of address 0 return data 0 and busy 0.
- pending_cnt: a registered population count of busy[], updated on the same edge as busy[].
  - Increments only when a bit transitions 0->1.
  - Decrements only when a bit transitions 1->0.
  - Net +1, 0 or -1 per cycle.
  - Never exceeds NREGS (NREGS-1 with ZERO_R0=1).

## Timing
- Reset (async): all regs 0, all busy 0, pending_cnt 0. data_a/data_b = 0 and busy_a/busy_b = 0 for any address while reset is asserted.
- Reset asserted mid-operation: all pending marks are discarded immediately. Writes presented in the same cycle are lost.
- Write-to-read latency: 1 cycle. A value written at edge N is visible on the read ports after edge N.
- Busy mark latency: 1 cycle. busy_x rises after the edge that samples set_busy.
- Same-cycle read of the address being written returns the old value and old busy unless bypass is compiled in (see Configuration).
- No handshakes. All inputs are sampled every edge, with no back-pressure.

## Configuration
- REGFILE_BYPASS_EN defined: write-through bypass on both read ports.
  - When we=1 and addr_x==addr_w (and not the ZERO_R0 address), data_x = data_w combinationally.
  - busy_x = 1 only if set_busy=1 and addr_busy==addr_x in the same cycle; otherwise busy_x = 0.
  - Other addresses are unaffected.
  - The bypass path never alters stored state or pending_cnt.
- Undefined: no bypass. Reads return stored state only, and same-cycle write data is visible one cycle later.

## Test plan
- Reset then read all: assert reset mid-run after writes -> all addresses read 0, busy 0, pending_cnt 0 immediately. Subsequent write r3=0xA5A5 -> read r3=0xA5A5 next cycle.
- Scoreboard lifecycle: set_busy r5 -> busy_a(r5)=1, pending_cnt=1. Later we r5=0x1234 -> busy_a=0, data_a=0x1234, pending_cnt=0.
- Collision: set_busy r2 and we r2=0x00FF same edge -> regs[2]=0x00FF, busy[2]=1, pending_cnt +1. set_busy r1 with we r4 same edge -> busy[1]=1, busy[4]=0.
- ZERO_R0=1: we r0=0xFFFF and set_busy r0 -> data_a(r0)=0, busy_a(r0)=0, pending_cnt unchanged. ZERO_R0=0: r0 reads 0xFFFF.
- Bypass: we r6=0xBEEF with addr_a=addr_b=6 in the same cycle.
  - With REGFILE_BYPASS_EN: data_a=data_b=0xBEEF that cycle.
  - Without REGFILE_BYPASS_EN: old value that cycle, 0xBEEF next cycle.
- Parameter sweep DATA_W=32, ADDR_W=4: mark all 16 registers busy -> pending_cnt=16. Write each back with pattern 0xC0DE0000|i -> correct data per register, pending_cnt=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREGS x DATA_W register file, two combinational read ports,
// one write-back port and a per-register busy scoreboard. Optional macro: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] data_w,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] addr_busy,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   pending_cnt
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic              we_eff;
  logic              set_eff;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [1:0]        rd_busy;

  // A hardwired-zero r0 swallows both write-backs and busy marks.
  assign we_eff  = we       && !(ZERO_R0 && (addr_w == '0));
  assign set_eff = set_busy && !(ZERO_R0 && (addr_busy == '0));

  // Retirement clears first so a same-address issue in the same cycle wins.
  always_comb begin
    busy_next = busy;
    if (we_eff)  busy_next[addr_w]    = 1'b0;
    if (set_eff) busy_next[addr_busy] = 1'b1;
  end

  assign cnt_inc = set_eff && !busy[addr_busy];
  assign cnt_dec = we_eff && busy[addr_w] && !(set_eff && (addr_busy == addr_w));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      if (we_eff) regs[addr_w] <= data_w;
      busy        <= busy_next;
      pending_cnt <= pending_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  assign rd_addr[0] = addr_a;
  assign rd_addr[1] = addr_b;

  // Reads are forced to zero while reset is held so bypassed data cannot leak out.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (we_eff && (rd_addr[p] == addr_w)) begin
        rd_data[p] = data_w;
        rd_busy[p] = set_eff && (addr_busy == rd_addr[p]);
      end
`endif
      if (reset || (ZERO_R0 && (rd_addr[p] == '0))) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign data_a = rd_data[0];
  assign data_b = rd_data[1];
  assign busy_a = rd_busy[0];
  assign busy_b = rd_busy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: table vectors plus a reference-model scoreboard for the default,
// hardwired-r0 and 32-bit x 16 configurations of regfile_scoreboard.
module tb_regfile_scoreboard;

  typedef struct {
    logic        we;
    logic [2:0]  addr_w;
    logic [15:0] data_w;
    logic        set_busy;
    logic [2:0]  addr_busy;
    logic [2:0]  addr_a;
    logic [2:0]  addr_b;
    logic [15:0] exp_da;
    logic        exp_ba;
    logic [15:0] exp_db;
    logic        exp_bb;
    logic [3:0]  exp_cnt;
  } vec_t;

  typedef struct {
    logic [15:0] da;
    logic        ba;
    logic [15:0] db;
    logic        bb;
    logic [3:0]  cnt;
    logic [15:0] zda;
    logic        zba;
    logic [15:0] zdb;
    logic        zbb;
    logic [3:0]  zcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, set_busy;
  logic [2:0]  addr_w, addr_busy, addr_a, addr_b;
  logic [15:0] data_w;
  logic [15:0] data_a, data_b, z_data_a, z_data_b;
  logic        busy_a, busy_b, z_busy_a, z_busy_b;
  logic [3:0]  pending_cnt, z_pending_cnt;

  logic        w_we, w_set_busy;
  logic [3:0]  w_addr_w, w_addr_busy, w_addr_a, w_addr_b;
  logic [31:0] w_data_w, w_data_a, w_data_b;
  logic        w_busy_a, w_busy_b;
  logic [4:0]  w_pending_cnt;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_regs [8];
  logic [7:0]  m_busy;
  exp_t        sb_q [$];
  vec_t        table_v [12];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .we(we), .addr_w(addr_w), .data_w(data_w),
    .set_busy(set_busy), .addr_busy(addr_busy), .addr_a(addr_a), .addr_b(addr_b),
    .data_a(data_a), .data_b(data_b), .busy_a(busy_a), .busy_b(busy_b),
    .pending_cnt(pending_cnt)
  );

  regfile_scoreboard #(.ZERO_R0(1'b1)) dut_z (
    .clk(clk), .reset(reset), .we(we), .addr_w(addr_w), .data_w(data_w),
    .set_busy(set_busy), .addr_busy(addr_busy), .addr_a(addr_a), .addr_b(addr_b),
    .data_a(z_data_a), .data_b(z_data_b), .busy_a(z_busy_a), .busy_b(z_busy_b),
    .pending_cnt(z_pending_cnt)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(4)) dut_w (
    .clk(clk), .reset(reset), .we(w_we), .addr_w(w_addr_w), .data_w(w_data_w),
    .set_busy(w_set_busy), .addr_busy(w_addr_busy), .addr_a(w_addr_a), .addr_b(w_addr_b),
    .data_a(w_data_a), .data_b(w_data_b), .busy_a(w_busy_a), .busy_b(w_busy_b),
    .pending_cnt(w_pending_cnt)
  );

  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  function automatic vec_t mkVec(input logic we_i, input logic [2:0] aw, input logic [15:0] dw,
                                 input logic sb, input logic [2:0] ab, input logic [2:0] ra,
                                 input logic [2:0] rb, input logic [15:0] eda, input logic eba,
                                 input logic [15:0] edb, input logic ebb, input logic [3:0] ec);
    vec_t v;
    v.we = we_i; v.addr_w = aw; v.data_w = dw; v.set_busy = sb; v.addr_busy = ab;
    v.addr_a = ra; v.addr_b = rb; v.exp_da = eda; v.exp_ba = eba; v.exp_db = edb;
    v.exp_bb = ebb; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic checkVal(input string name, input string field, input logic [31:0] got,
                          input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s.%s got %h want %h", name, field, got, want);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_busy = 8'h0;
  endtask

  // Drive one cycle of stimulus, advance the model, and queue what should be seen after the edge.
  task automatic applyStimulus(input vec_t v, input bit use_table);
    exp_t e;
    we = v.we; addr_w = v.addr_w; data_w = v.data_w;
    set_busy = v.set_busy; addr_busy = v.addr_busy;
    addr_a = v.addr_a; addr_b = v.addr_b;
    if (v.we) begin
      m_regs[v.addr_w] = v.data_w;
      m_busy[v.addr_w] = 1'b0;
    end
    if (v.set_busy) m_busy[v.addr_busy] = 1'b1;
    e.da   = m_regs[v.addr_a];
    e.ba   = m_busy[v.addr_a];
    e.db   = m_regs[v.addr_b];
    e.bb   = m_busy[v.addr_b];
    e.cnt  = popcnt(m_busy);
    e.zda  = (v.addr_a == 3'd0) ? 16'h0 : m_regs[v.addr_a];
    e.zba  = (v.addr_a == 3'd0) ? 1'b0  : m_busy[v.addr_a];
    e.zdb  = (v.addr_b == 3'd0) ? 16'h0 : m_regs[v.addr_b];
    e.zbb  = (v.addr_b == 3'd0) ? 1'b0  : m_busy[v.addr_b];
    e.zcnt = popcnt(m_busy & 8'hFE);
    if (use_table) begin
      e.da = v.exp_da; e.ba = v.exp_ba; e.db = v.exp_db; e.bb = v.exp_bb; e.cnt = v.exp_cnt;
    end
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s.queue got empty want entry", name);
      return;
    end
    e = sb_q.pop_front();
    checkVal(name, "data_a", data_a, e.da);
    checkVal(name, "busy_a", busy_a, e.ba);
    checkVal(name, "data_b", data_b, e.db);
    checkVal(name, "busy_b", busy_b, e.bb);
    checkVal(name, "pending_cnt", pending_cnt, e.cnt);
    checkVal(name, "z_data_a", z_data_a, e.zda);
    checkVal(name, "z_busy_a", z_busy_a, e.zba);
    checkVal(name, "z_data_b", z_data_b, e.zdb);
    checkVal(name, "z_busy_b", z_busy_b, e.zbb);
    checkVal(name, "z_pending_cnt", z_pending_cnt, e.zcnt);
  endtask

  // Clock the queued stimulus in, then read back stored state with the write ports idle.
  task automatic finishCycle(input string name);
    @(posedge clk);
    #1;
    we = 1'b0;
    set_busy = 1'b0;
    #1;
    checkOutput(name);
    @(negedge clk);
  endtask

  initial begin
    vec_t        v;
    logic [15:0] old_d;
    logic        old_b;
    logic [3:0]  zcnt_before;

    table_v[0]  = mkVec(1, 3'd3, 16'hA5A5, 0, 3'd0, 3'd3, 3'd0, 16'hA5A5, 0, 16'h0000, 0, 4'd0);
    table_v[1]  = mkVec(0, 3'd0, 16'h0000, 1, 3'd5, 3'd5, 3'd3, 16'h0000, 1, 16'hA5A5, 0, 4'd1);
    table_v[2]  = mkVec(1, 3'd5, 16'h1234, 0, 3'd0, 3'd5, 3'd5, 16'h1234, 0, 16'h1234, 0, 4'd0);
    table_v[3]  = mkVec(1, 3'd2, 16'h00FF, 1, 3'd2, 3'd2, 3'd5, 16'h00FF, 1, 16'h1234, 0, 4'd1);
    table_v[4]  = mkVec(1, 3'd4, 16'h4444, 1, 3'd1, 3'd1, 3'd4, 16'h0000, 1, 16'h4444, 0, 4'd2);
    table_v[5]  = mkVec(1, 3'd7, 16'h7777, 0, 3'd0, 3'd7, 3'd2, 16'h7777, 0, 16'h00FF, 1, 4'd2);
    table_v[6]  = mkVec(0, 3'd0, 16'h0000, 1, 3'd2, 3'd2, 3'd1, 16'h00FF, 1, 16'h0000, 1, 4'd2);
    table_v[7]  = mkVec(1, 3'd2, 16'h2222, 1, 3'd2, 3'd2, 3'd2, 16'h2222, 1, 16'h2222, 1, 4'd2);
    table_v[8]  = mkVec(1, 3'd1, 16'h1111, 1, 3'd6, 3'd1, 3'd6, 16'h1111, 0, 16'h0000, 1, 4'd2);
    table_v[9]  = mkVec(1, 3'd2, 16'h0202, 0, 3'd0, 3'd2, 3'd0, 16'h0202, 0, 16'h0000, 0, 4'd1);
    table_v[10] = mkVec(1, 3'd6, 16'h6666, 0, 3'd0, 3'd6, 3'd3, 16'h6666, 0, 16'hA5A5, 0, 4'd0);
    table_v[11] = mkVec(1, 3'd0, 16'hFFFF, 0, 3'd0, 3'd0, 3'd7, 16'hFFFF, 0, 16'h7777, 0, 4'd0);

    reset = 1'b1;
    we = 1'b0; set_busy = 1'b0; addr_w = 3'd0; addr_busy = 3'd0; data_w = 16'h0;
    addr_a = 3'd0; addr_b = 3'd7;
    w_we = 1'b0; w_set_busy = 1'b0; w_addr_w = 4'd0; w_addr_busy = 4'd0; w_data_w = 32'h0;
    w_addr_a = 4'd0; w_addr_b = 4'd15;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkVal("reset", "data_a", data_a, 16'h0);
    checkVal("reset", "busy_b", busy_b, 1'b0);
    checkVal("reset", "pending_cnt", pending_cnt, 4'd0);
    checkVal("reset", "w_pending_cnt", w_pending_cnt, 5'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(table_v[i], 1'b1);
      finishCycle($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      v = mkVec(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom()),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 16'h0, 1'b0, 16'h0, 1'b0, 4'd0);
      applyStimulus(v, 1'b0);
      finishCycle($sformatf("rand%0d", i));
    end

    // Same-cycle read of the register being written: bypass or old contents.
    old_d = m_regs[6];
    old_b = m_busy[6];
    applyStimulus(mkVec(1, 3'd6, 16'hBEEF, 0, 3'd0, 3'd6, 3'd6, 16'h0, 0, 16'h0, 0, 4'd0), 1'b0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkVal("bypass0", "data_a", data_a, 16'hBEEF);
    checkVal("bypass0", "data_b", data_b, 16'hBEEF);
    checkVal("bypass0", "busy_a", busy_a, 1'b0);
`else
    checkVal("bypass0", "data_a", data_a, old_d);
    checkVal("bypass0", "data_b", data_b, old_d);
    checkVal("bypass0", "busy_a", busy_a, old_b);
`endif
    finishCycle("bypass0_next");

    applyStimulus(mkVec(1, 3'd6, 16'hBEE0, 1, 3'd6, 3'd6, 3'd6, 16'h0, 0, 16'h0, 0, 4'd0), 1'b0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkVal("bypass1", "data_a", data_a, 16'hBEE0);
    checkVal("bypass1", "busy_b", busy_b, 1'b1);
`else
    checkVal("bypass1", "data_a", data_a, 16'hBEEF);
    checkVal("bypass1", "busy_b", busy_b, 1'b0);
`endif
    finishCycle("bypass1_next");

    // r0 write plus mark: stored and busy on the plain file, ignored on the zero-r0 file.
    zcnt_before = popcnt(m_busy & 8'hFE);
    applyStimulus(mkVec(1, 3'd0, 16'hFFFF, 1, 3'd0, 3'd0, 3'd0, 16'h0, 0, 16'h0, 0, 4'd0), 1'b0);
    finishCycle("r0_write");
    checkVal("r0_write", "data_a_plain", data_a, 16'hFFFF);
    checkVal("r0_write", "z_cnt_unchanged", z_pending_cnt, zcnt_before);

    // Reset mid-cycle with a write and a mark in flight: everything reads zero at once.
    we = 1'b1; addr_w = 3'd3; data_w = 16'h1111; set_busy = 1'b1; addr_busy = 3'd4;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      addr_a = 3'(i);
      addr_b = 3'(7 - i);
      #1;
      checkVal($sformatf("rst_mid%0d", i), "data_a", data_a, 16'h0);
      checkVal($sformatf("rst_mid%0d", i), "busy_a", busy_a, 1'b0);
      checkVal($sformatf("rst_mid%0d", i), "data_b", data_b, 16'h0);
      checkVal($sformatf("rst_mid%0d", i), "busy_b", busy_b, 1'b0);
    end
    checkVal("rst_mid", "pending_cnt", pending_cnt, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    we = 1'b0;
    set_busy = 1'b0;
    modelReset();
    addr_a = 3'd3;
    #1;
    checkVal("rst_after", "data_a_lost_write", data_a, 16'h0);
    checkVal("rst_after", "pending_cnt", pending_cnt, 4'd0);
    applyStimulus(mkVec(1, 3'd3, 16'hA5A5, 0, 3'd0, 3'd3, 3'd3, 16'h0, 0, 16'h0, 0, 4'd0), 1'b0);
    finishCycle("rst_write_r3");

    // Wide configuration: fill the scoreboard, then retire every register.
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      w_set_busy = 1'b1;
      w_addr_busy = 4'(i);
      @(posedge clk);
      #1;
    end
    w_set_busy = 1'b0;
    w_addr_a = 4'd9;
    #1;
    checkVal("wide_fill", "pending_cnt", w_pending_cnt, 5'd16);
    checkVal("wide_fill", "busy_a", w_busy_a, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      w_we = 1'b1;
      w_addr_w = 4'(i);
      w_data_w = 32'hC0DE_0000 | 32'(i);
      @(posedge clk);
      #1;
      if (i == 7) checkVal("wide_half", "pending_cnt", w_pending_cnt, 5'd8);
    end
    w_we = 1'b0;
    #1;
    checkVal("wide_drain", "pending_cnt", w_pending_cnt, 5'd0);
    for (int i = 0; i < 16; i++) begin
      w_addr_a = 4'(i);
      w_addr_b = 4'(15 - i);
      #1;
      checkVal($sformatf("wide_rd%0d", i), "data_a", w_data_a, 32'hC0DE_0000 | 32'(i));
      checkVal($sformatf("wide_rd%0d", i), "data_b", w_data_b, 32'hC0DE_0000 | 32'(15 - i));
      checkVal($sformatf("wide_rd%0d", i), "busy_a", w_busy_a, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
